// File: rtl/slot_ctrl_pkg.sv
// rtl/slot_ctrl_pkg.sv - shared encodings for the slot controller FSM and datapath selects
package slot_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_START   = 3'd0,
    ST_IOWAIT  = 3'd1,
    ST_DECODE  = 3'd2,
    ST_DIVWAIT = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_SYSCALL = 4'd1;
  localparam logic [3:0] OP_LOAD    = 4'd2;
  localparam logic [3:0] OP_STORE   = 4'd3;
  localparam logic [3:0] OP_SWAPA   = 4'd4;
  localparam logic [3:0] OP_SWAPD   = 4'd5;
  localparam logic [3:0] OP_BRANCHZ = 4'd6;
  localparam logic [3:0] OP_BRANCHN = 4'd7;
  localparam logic [3:0] OP_JUMP    = 4'd8;
  localparam logic [3:0] OP_CONST   = 4'd9;
  localparam logic [3:0] OP_ADD     = 4'd10;
  localparam logic [3:0] OP_SUB     = 4'd11;
  localparam logic [3:0] OP_MUL     = 4'd12;
  localparam logic [3:0] OP_DIV     = 4'd13;
  localparam logic [3:0] OP_SHIFT   = 4'd14;
  localparam logic [3:0] OP_NAND    = 4'd15;

  localparam logic       SELADDR_PC   = 1'b0;
  localparam logic       SELADDR_AR   = 1'b1;
  localparam logic [1:0] SELACC_MEM   = 2'd0;
  localparam logic [1:0] SELACC_IO    = 2'd1;
  localparam logic [1:0] SELACC_SWAP  = 2'd2;
  localparam logic [1:0] SELACC_ALU   = 2'd3;
  localparam logic       SELSWAP_AR   = 1'b0;
  localparam logic       SELSWAP_DR   = 1'b1;
  localparam logic       SELPC1_NEXT  = 1'b0;
  localparam logic       SELPC1_REG   = 1'b1;
  localparam logic       SELPC2_AR    = 1'b0;
  localparam logic       SELPC2_ACC   = 1'b1;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_MUL   = 3'd2;
  localparam logic [2:0] ALU_DIV   = 3'd3;
  localparam logic [2:0] ALU_SHIFT = 3'd4;
  localparam logic [2:0] ALU_NAND  = 3'd5;

  // Single-cycle ALU opcodes map onto the ALU op field; anything else reads as ADD.
  function automatic logic [2:0] alu_of(input logic [3:0] op);
    case (op)
      OP_SUB:   return ALU_SUB;
      OP_MUL:   return ALU_MUL;
      OP_DIV:   return ALU_DIV;
      OP_SHIFT: return ALU_SHIFT;
      OP_NAND:  return ALU_NAND;
      default:  return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/slot_div_timer.sv
// rtl/slot_div_timer.sv - loadable down-counter that times the divider's extra cycles
module slot_div_timer #(
  parameter int DIV_LAT = 3,
  parameter int CNT_W   = $clog2(DIV_LAT + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic done
);

  logic [CNT_W-1:0] count;

  // Saturates at zero, so it only runs down after a load and then rests.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(DIV_LAT - 1);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/slot_controller.sv
// rtl/slot_controller.sv - Sextium control FSM sequencing packed opcode slots of a fetched word
module slot_controller
  import slot_ctrl_pkg::*;
#(
  parameter int SLOTS   = 4,
  parameter int SLOT_W  = $clog2(SLOTS),
  parameter int DIV_LAT = 3,
  parameter int CNT_W   = $clog2(DIV_LAT + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        insn,
  input  logic              accz,
  input  logic              accn,
  input  logic              iobusy,
  input  logic              mem_ack,
  input  logic              halt_req,
  input  logic              step,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic              pc_write,
  output logic              acc_write,
  output logic              seladdr,
  output logic [1:0]        selacc,
  output logic              selswap,
  output logic              doswap,
  output logic              selpc1,
  output logic              selpc2,
  output logic [SLOT_W-1:0] curinsn,
  output logic [2:0]        aluinsn,
  output logic              runio,
  output logic              diven,
  output logic [2:0]        stateout,
  output logic              halted
);

  state_t             state, state_nxt;
  logic [SLOT_W-1:0]  slot, slot_nxt;
  logic               resume, resume_nxt;
  logic               adv, jump;
  logic               div_load, div_done;
  logic               last_slot;

  assign last_slot = (slot == SLOT_W'(SLOTS - 1));

  slot_div_timer #(
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_div_timer (
    .clock (clock),
    .reset (reset),
    .load  (div_load),
    .done  (div_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_START;
      slot   <= '0;
      resume <= 1'b0;
    end else begin
      state  <= state_nxt;
      slot   <= slot_nxt;
      resume <= resume_nxt;
    end
  end

  // resume lets the first fetch after leaving HALT ignore a still-asserted halt_req.
  always_comb begin
    state_nxt  = state;
    slot_nxt   = slot;
    resume_nxt = resume;
    adv        = 1'b0;
    jump       = 1'b0;
    div_load   = 1'b0;
    case (state)
      ST_START: begin
        if (halt_req && !resume) begin
          state_nxt = ST_HALT;
        end else if (mem_ack) begin
          state_nxt  = ST_DECODE;
          slot_nxt   = '0;
          resume_nxt = 1'b0;
        end
      end
      ST_HALT: begin
        if (step || !halt_req) begin
          state_nxt  = ST_START;
          resume_nxt = 1'b1;
        end
      end
      ST_DECODE: begin
        case (insn)
          OP_LOAD, OP_STORE, OP_CONST: adv = mem_ack;
          OP_BRANCHZ: begin
            jump = accz;
            adv  = !accz;
          end
          OP_BRANCHN: begin
            jump = accn;
            adv  = !accn;
          end
          OP_JUMP:    jump = 1'b1;
          OP_SYSCALL: state_nxt = ST_IOWAIT;
          OP_DIV: begin
            state_nxt = ST_DIVWAIT;
            div_load  = 1'b1;
          end
          default:    adv = 1'b1;
        endcase
      end
      ST_IOWAIT:  adv = !iobusy;
      ST_DIVWAIT: adv = div_done;
      default:    state_nxt = ST_START;
    endcase

    // Wrap by explicit compare so a non-power-of-two SLOTS never indexes past the word.
    if (jump) begin
      state_nxt = ST_START;
      slot_nxt  = '0;
    end else if (adv) begin
      if (last_slot) begin
        state_nxt = ST_START;
        slot_nxt  = '0;
      end else begin
        state_nxt = ST_DECODE;
        slot_nxt  = slot + SLOT_W'(1);
      end
    end
  end

  // Outputs are forced idle while reset is held so nothing strobes during the reset cycle.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    acc_write = 1'b0;
    seladdr   = SELADDR_PC;
    selacc    = SELACC_MEM;
    selswap   = SELSWAP_AR;
    doswap    = 1'b0;
    selpc1    = SELPC1_NEXT;
    selpc2    = SELPC2_AR;
    aluinsn   = ALU_ADD;
    runio     = 1'b0;
    diven     = 1'b0;
    halted    = 1'b0;
    if (reset) begin
      case (state)
        ST_START: begin
          if (!(halt_req && !resume)) begin
            mem_read = 1'b1;
            ir_write = 1'b1;
            seladdr  = SELADDR_PC;
            if (mem_ack) begin
              pc_write = 1'b1;
              selpc1   = SELPC1_NEXT;
            end
          end
        end
        ST_HALT: halted = 1'b1;
        ST_DECODE: begin
          case (insn)
            OP_LOAD: begin
              mem_read  = 1'b1;
              seladdr   = SELADDR_AR;
              selacc    = SELACC_MEM;
              acc_write = 1'b1;
            end
            OP_STORE: begin
              mem_write = 1'b1;
              seladdr   = SELADDR_AR;
            end
            OP_CONST: begin
              mem_read  = 1'b1;
              seladdr   = SELADDR_PC;
              selacc    = SELACC_MEM;
              acc_write = 1'b1;
              if (mem_ack) begin
                pc_write = 1'b1;
                selpc1   = SELPC1_NEXT;
              end
            end
            OP_SWAPA, OP_SWAPD: begin
              selacc    = SELACC_SWAP;
              acc_write = 1'b1;
              doswap    = 1'b1;
              selswap   = (insn == OP_SWAPD) ? SELSWAP_DR : SELSWAP_AR;
            end
            OP_ADD, OP_SUB, OP_MUL, OP_SHIFT, OP_NAND: begin
              selacc    = SELACC_ALU;
              acc_write = 1'b1;
              aluinsn   = alu_of(insn);
            end
            OP_BRANCHZ, OP_BRANCHN: begin
              if ((insn == OP_BRANCHZ) ? accz : accn) begin
                pc_write = 1'b1;
                selpc1   = SELPC1_REG;
                selpc2   = SELPC2_AR;
              end
            end
            OP_JUMP: begin
              pc_write = 1'b1;
              selpc1   = SELPC1_REG;
              selpc2   = SELPC2_ACC;
            end
            OP_SYSCALL: begin
              runio   = 1'b1;
              seladdr = SELADDR_AR;
              selacc  = SELACC_IO;
            end
            OP_DIV: begin
              aluinsn = ALU_DIV;
              diven   = 1'b1;
            end
            default: ;
          endcase
        end
        ST_IOWAIT: begin
          selacc = SELACC_IO;
          runio  = iobusy;
        end
        ST_DIVWAIT: begin
          aluinsn   = ALU_DIV;
          selacc    = SELACC_ALU;
          diven     = 1'b1;
          acc_write = div_done;
        end
        default: ;
      endcase
    end
  end

  assign curinsn  = slot;
  assign stateout = state;

endmodule

// File: tb/tb_slot_controller.sv
// tb/tb_slot_controller.sv - directed vector bench for slot_controller
module tb_slot_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] insn = '0;
  logic       accz = 1'b0, accn = 1'b0, iobusy = 1'b0, mem_ack = 1'b0;
  logic       halt_req = 1'b0, step = 1'b0;
  logic       mem_read, mem_write, ir_write, pc_write, acc_write;
  logic       seladdr, selswap, doswap, selpc1, selpc2, runio, diven, halted;
  logic [1:0] selacc, curinsn;
  logic [2:0] aluinsn, stateout;

  slot_controller #(.SLOTS(4), .DIV_LAT(3)) dut (
    .clock(clock), .reset(reset), .insn(insn), .accz(accz), .accn(accn),
    .iobusy(iobusy), .mem_ack(mem_ack), .halt_req(halt_req), .step(step),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .acc_write(acc_write), .seladdr(seladdr),
    .selacc(selacc), .selswap(selswap), .doswap(doswap), .selpc1(selpc1),
    .selpc2(selpc2), .curinsn(curinsn), .aluinsn(aluinsn), .runio(runio),
    .diven(diven), .stateout(stateout), .halted(halted)
  );

  always #5 clock = ~clock;

  // strobe vector {mr, mw, irw, pcw, accw, runio, diven, doswap, halted}
  localparam logic [8:0] MR = 9'h100, MW = 9'h080, IRW = 9'h040, PCW = 9'h020, ACW = 9'h010;
  localparam logic [8:0] RIO = 9'h008, DVN = 9'h004, DSW = 9'h002, HLT = 9'h001;
  // select vector {seladdr, selacc[1:0], selswap, selpc1, selpc2, aluinsn[2:0]}
  localparam logic [8:0] A_AR = 9'h100, C_IO = 9'h040, C_SWAP = 9'h080, C_ALU = 9'h0C0;
  localparam logic [8:0] S_DR = 9'h020, P1_REG = 9'h010, P2_ACC = 9'h008;
  localparam logic [8:0] MA = 9'h100, MC = 9'h0C0, MS = 9'h020, M1 = 9'h010, M2 = 9'h008, ML = 9'h007;
  localparam logic [8:0] FETCH = MR | IRW | PCW;

  logic [8:0] strb_act, sel_act;
  assign strb_act = {mem_read, mem_write, ir_write, pc_write, acc_write, runio, diven, doswap, halted};
  assign sel_act  = {seladdr, selacc, selswap, selpc1, selpc2, aluinsn};

  typedef struct {
    logic [3:0] insn;
    logic       ack, z, n, busy, hlt, stp;
    logic [2:0] st;
    logic [1:0] cur;
    logic [8:0] strb, sel, msk;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  task automatic v(input logic [3:0] i_insn, input logic i_ack, i_z, i_n, i_busy, i_hlt, i_stp,
                   input logic [2:0] e_st, input logic [1:0] e_cur,
                   input logic [8:0] e_strb, e_sel, e_msk);
    vec_t r;
    r.insn = i_insn; r.ack = i_ack; r.z = i_z; r.n = i_n; r.busy = i_busy;
    r.hlt = i_hlt; r.stp = i_stp; r.st = e_st; r.cur = e_cur;
    r.strb = e_strb; r.sel = e_sel; r.msk = e_msk;
    vecs.push_back(r);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", nm, idx, act, req);
    end
  endtask

  initial begin
    // word 1: ADD SUB NAND NOP
    v(0, 1,0,0,0,0,0, 0,0, FETCH, 0, MA|M1);
    v(10,0,0,0,0,0,0, 2,0, ACW, C_ALU|9'd0, MC|ML);
    v(11,0,0,0,0,0,0, 2,1, ACW, C_ALU|9'd1, MC|ML);
    v(15,0,0,0,0,0,0, 2,2, ACW, C_ALU|9'd5, MC|ML);
    v(0, 0,0,0,0,0,0, 2,3, 0, 0, 0);
    // word 2: LOAD (ack late) STORE CONST DIV
    v(0, 1,0,0,0,0,0, 0,0, FETCH, 0, MA|M1);
    v(2, 0,0,0,0,0,0, 2,0, MR|ACW, A_AR, MA|MC);
    v(2, 0,0,0,0,0,0, 2,0, MR|ACW, A_AR, MA|MC);
    v(2, 1,0,0,0,0,0, 2,0, MR|ACW, A_AR, MA|MC);
    v(3, 1,0,0,0,0,0, 2,1, MW, A_AR, MA);
    v(9, 1,0,0,0,0,0, 2,2, MR|ACW|PCW, 0, MA|MC|M1);
    v(13,0,0,0,0,0,0, 2,3, DVN, 9'd3, ML);
    v(0, 0,0,0,0,0,0, 3,3, DVN, C_ALU|9'd3, MC|ML);
    v(0, 0,0,0,0,0,0, 3,3, DVN, C_ALU|9'd3, MC|ML);
    v(0, 0,0,0,0,0,0, 3,3, DVN|ACW, C_ALU|9'd3, MC|ML);
    // word 3: SWAPA, BRANCHZ taken
    v(0, 1,0,0,0,0,0, 0,0, FETCH, 0, MA|M1);
    v(4, 0,0,0,0,0,0, 2,0, ACW|DSW, C_SWAP, MC|MS);
    v(6, 0,1,0,0,0,0, 2,1, PCW, P1_REG, M1|M2);
    // word 4: SWAPD, BRANCHZ not taken, SYSCALL busy 5 cycles, BRANCHN taken
    v(0, 1,0,0,0,0,0, 0,0, FETCH, 0, MA|M1);
    v(5, 0,0,0,0,0,0, 2,0, ACW|DSW, C_SWAP|S_DR, MC|MS);
    v(6, 0,0,0,0,0,0, 2,1, 0, 0, 0);
    v(1, 0,0,0,1,0,0, 2,2, RIO, A_AR|C_IO, MA|MC);
    for (int k = 0; k < 4; k++) v(1, 0,0,0,1,0,0, 1,2, RIO, C_IO, MC);
    v(1, 0,0,0,0,0,0, 1,2, 0, C_IO, MC);
    v(7, 0,0,1,0,0,0, 2,3, PCW, P1_REG, M1|M2);
    // word 5: JUMP
    v(0, 1,0,0,0,0,0, 0,0, FETCH, 0, MA|M1);
    v(8, 0,0,0,0,0,0, 2,0, PCW, P1_REG|P2_ACC, M1|M2);
    // word 6: slow fetch, halt requested mid-word, held LOAD keeps waiting
    v(0, 0,0,0,0,0,0, 0,0, MR|IRW, 0, MA);
    v(0, 1,0,0,0,0,0, 0,0, FETCH, 0, MA|M1);
    v(12,0,0,0,0,1,0, 2,0, ACW, C_ALU|9'd2, MC|ML);
    v(14,0,0,0,0,1,0, 2,1, ACW, C_ALU|9'd4, MC|ML);
    v(2, 0,0,0,0,1,0, 2,2, MR|ACW, A_AR, MA|MC);
    v(2, 1,0,0,0,1,0, 2,2, MR|ACW, A_AR, MA|MC);
    v(0, 0,0,0,0,1,0, 2,3, 0, 0, 0);
    v(0, 0,0,0,0,1,0, 0,0, 0, 0, 0);
    v(0, 0,0,0,0,1,0, 4,0, HLT, 0, 0);
    v(0, 0,0,0,0,1,0, 4,0, HLT, 0, 0);
    v(0, 0,0,0,0,1,1, 4,0, HLT, 0, 0);
    // single step: one fetch + word, then back to HALT
    v(0, 1,0,0,0,1,0, 0,0, FETCH, 0, MA|M1);
    for (int k = 0; k < 4; k++) v(0, 0,0,0,0,1,0, 2,2'(k), 0, 0, 0);
    v(0, 0,0,0,0,1,0, 0,0, 0, 0, 0);
    v(0, 0,0,0,0,1,0, 4,0, HLT, 0, 0);
    v(0, 0,0,0,0,0,0, 4,0, HLT, 0, 0);
    // resume, DIV at slot 1 for the reset-abort case
    v(0, 1,0,0,0,0,0, 0,0, FETCH, 0, MA|M1);
    v(0, 0,0,0,0,0,0, 2,0, 0, 0, 0);
    v(13,0,0,0,0,0,0, 2,1, DVN, 9'd3, ML);
    v(0, 0,0,0,0,0,0, 3,1, DVN, C_ALU|9'd3, MC|ML);

    repeat (2) @(posedge clock);
    #1;
    chk("rst_state", -1, 32'(stateout), 0);
    chk("rst_cur", -1, 32'(curinsn), 0);
    chk("rst_strb", -1, 32'(strb_act), 0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      insn = vecs[i].insn; mem_ack = vecs[i].ack; accz = vecs[i].z; accn = vecs[i].n;
      iobusy = vecs[i].busy; halt_req = vecs[i].hlt; step = vecs[i].stp;
      #2;
      chk("state", i, 32'(stateout), 32'(vecs[i].st));
      chk("curinsn", i, 32'(curinsn), 32'(vecs[i].cur));
      chk("strobes", i, 32'(strb_act), 32'(vecs[i].strb));
      if (vecs[i].msk != 0)
        chk("selects", i, 32'(sel_act & vecs[i].msk), 32'(vecs[i].sel & vecs[i].msk));
    end

    // async reset in DIVWAIT aborts at once, before any clock edge
    @(negedge clock);
    insn = 0; mem_ack = 0; step = 0; halt_req = 0;
    #1;
    chk("pre_abort_state", -2, 32'(stateout), 3);
    #1 reset = 1'b0;
    #1;
    chk("abort_state", -2, 32'(stateout), 0);
    chk("abort_cur", -2, 32'(curinsn), 0);
    chk("abort_strb", -2, 32'(strb_act), 0);
    @(posedge clock);
    #1;
    chk("abort_hold_strb", -2, 32'(strb_act), 0);
    @(negedge clock);
    reset = 1'b1;
    #2;
    chk("post_reset_state", -3, 32'(stateout), 0);
    chk("post_reset_strb", -3, 32'(strb_act), 32'(MR | IRW));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
